// File: rtl/r4_data_mem_mmio.sv
// R4 data memory: byte-addressed RAM, LED register and UART transmitter.
// Ports: clk, n_reset (sync, active-low); CPU side addr/din/we/size/
//   load_unsigned in, dout/misaligned out; board side led[7:0], tx.
module r4_data_mem_mmio #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned CLK_HZ         = 25000000,
   parameter int unsigned BAUD           = 115200,
   parameter logic [31:0] LED_ADDR       = 32'h0000_8000,
   parameter logic [31:0] UART_DATA_ADDR = 32'h0000_8004,
   parameter logic [31:0] UART_STAT_ADDR = 32'h0000_8008
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   output logic [31:0] dout,
   output logic        misaligned,
   output logic [7:0]  led,
   output logic        tx
);

   localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
   localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [32:0] RAM_END = 33'(DEPTH) << 2;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   logic                  sel_ram, sel_led, sel_udata, sel_ustat;
   logic                  wr_ok, busy;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           mem [DEPTH];
   logic [31:0]           word, wdata;
   logic [3:0]            be;
   logic [7:0]            rbyte;
   logic [15:0]           rhalf;

   uart_state_t state, state_n;
   logic [CW-1:0] baud_cnt, baud_n;
   logic [2:0]    bit_cnt, bit_n;
   logic [7:0]    tx_data, data_n;
   logic          overflow, ovf_n;

   // RAM wins the decode so a small MMIO address never aliases it.
   assign sel_ram   = {1'b0, addr} < RAM_END;
   assign sel_led   = !sel_ram && (addr == LED_ADDR);
   assign sel_udata = !sel_ram && (addr == UART_DATA_ADDR);
   assign sel_ustat = !sel_ram && (addr == UART_STAT_ADDR);
   assign idx       = addr[ADDR_WIDTH+1:2];

   always_comb begin
      unique case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr[0];
         default: misaligned = |addr[1:0];
      endcase
   end

   assign wr_ok = we && !misaligned;
   assign busy  = (state != IDLE);

   // Combinational read lanes.
   assign word  = mem[idx];
   assign rhalf = addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      unique case (addr[1:0])
         2'd0:    rbyte = word[7:0];
         2'd1:    rbyte = word[15:8];
         2'd2:    rbyte = word[23:16];
         default: rbyte = word[31:24];
      endcase
   end

   always_comb begin
      dout = '0;
      if (!misaligned) begin
         unique case (1'b1)
            sel_ram: begin
               unique case (size)
                  2'b00:   dout = {{24{rbyte[7] & !load_unsigned}}, rbyte};
                  2'b01:   dout = {{16{rhalf[15] & !load_unsigned}}, rhalf};
                  default: dout = word;
               endcase
            end
            sel_led:   dout = {24'b0, led};
            sel_ustat: dout = {30'b0, overflow, busy};
            default:   dout = '0;
         endcase
      end
   end

   // Store data is replicated across lanes; be picks the live ones.
   always_comb begin
      unique case (size)
         2'b00: begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{din[7:0]}};
         end
         2'b01: begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{din[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = din;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_ok && sel_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) led <= '0;
      else if (wr_ok && sel_led) led <= din[7:0];
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx_data  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         tx_data  <= data_n;
         overflow <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_cnt;
      data_n  = tx_data;
      ovf_n   = overflow;
      unique case (state)
         IDLE: begin
            if (wr_ok && sel_udata) begin
               state_n = START;
               data_n  = din[7:0];
               baud_n  = '0;
               bit_n   = '0;
            end
         end
         default: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_n = '0;
               unique case (state)
                  START: state_n = DATA;
                  DATA: begin
                     if (bit_cnt == 3'd7) state_n = STOP;
                     else bit_n = bit_cnt + 3'd1;
                  end
                  default: state_n = IDLE;
               endcase
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
      endcase
      // The last STOP cycle still counts as busy, so such a store drops.
      if (wr_ok && sel_udata && busy) ovf_n = 1'b1;
      if (wr_ok && sel_ustat) ovf_n = 1'b0;
   end

   always_comb begin
      unique case (state)
         START:   tx = 1'b0;
         DATA:    tx = tx_data[bit_cnt];
         default: tx = 1'b1;
      endcase
   end

endmodule
